// File: rtl/uart_tx_ctrl_if.sv
// Host-side write bundle and serial-side status of the UART transmitter.
// Latency: none, wires only.
// Backpressure: busy gates data_valid; requests seen while busy are dropped.
interface uart_tx_ctrl_if;
  logic       data_valid;
  logic [7:0] data_in;
  logic [1:0] parity_type;
  logic       tx_out;
  logic       busy;
  logic       done;
  logic       par_bit;

  // Host drives the request and observes line/status.
  modport master (
    output data_valid, data_in, parity_type,
    input  tx_out, busy, done, par_bit
  );

  // Transmitter consumes the request and drives line/status.
  modport slave (
    input  data_valid, data_in, parity_type,
    output tx_out, busy, done, par_bit
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: start, 8 data bits LSB first, optional parity, stop bit(s); UART_TX_STOP2_EN selects two stop bits.
// Latency: start bit appears 1 clk after data_valid is sampled in IDLE; frame = CLKS_PER_BIT*(10+P) clks (+CLKS_PER_BIT with two stops).
// Backpressure: data_valid is only sampled while idle (including the done cycle); anything offered while busy is dropped, not queued.

// Parity generator fed only from the sequencer's latches, so its output is stable for a whole frame.
module uart_tx_parity_gen (
  input  logic       rst_i,   // active-low; forces a zero output while asserted
  input  logic [7:0] data_i,
  input  logic [1:0] type_i,  // 00 none, 01 odd, 10 even, 11 odd (reported only)
  output logic       par_o
);
  // Odd-style types set the bit when the ones count is even; even mode when it is odd.
  always_comb begin
    par_o = 1'b0;
    unique case (type_i)
      2'b01, 2'b11: par_o = ~(^data_i);
      2'b10:        par_o = ^data_i;
      default:      par_o = 1'b0;
    endcase
    if (!rst_i) par_o = 1'b0;
  end
endmodule

module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_WIDTH   = 8
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_ctrl_if.slave bus
);
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
`ifdef UART_TX_STOP2_EN
  localparam int STOP_BITS = 2;
`else
  localparam int STOP_BITS = 1;
`endif
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST  = 3'(DATA_WIDTH - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2:0]            idx_q, idx_d;     // data bit index, reused as stop bit index
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic [1:0]            typ_q, typ_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  par_q;
  logic                  gen_par;
  logic                  bit_end;

  // Generator reset is tied inactive; it only ever sees the frame latches.
  uart_tx_parity_gen u_par (
    .rst_i  (1'b1),
    .data_i (dat_q),
    .type_i (typ_q),
    .par_o  (gen_par)
  );

  assign bit_end = (cnt_q == CNT_LAST);

  // Next-state, next-line and latch-load decode; tx/busy change on the same edge as the state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dat_d   = dat_q;
    typ_d   = typ_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (bus.data_valid) begin
          dat_d   = bus.data_in;
          typ_d   = bus.parity_type;
          cnt_d   = '0;
          state_d = S_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = '0;
          tx_d    = dat_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            if (typ_q == 2'b01 || typ_q == 2'b10) begin
              state_d = S_PARITY;
              tx_d    = gen_par;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = dat_q[idx_d];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          idx_d   = '0;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (idx_q == STOP_LAST) begin
            // The done cycle is a genuine IDLE cycle, so a request here starts the next frame.
            state_d = S_IDLE;
            idx_d   = '0;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame and returns the line high at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      dat_q   <= '0;
      typ_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dat_q   <= dat_d;
      typ_q   <= typ_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      par_q   <= gen_par;   // follows the latches one edge after acceptance
    end
  end

  assign bus.tx_out  = tx_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.par_bit = par_q;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: queue-based frame model compared every cycle,
// plus literal frame images, lengths and parity values for directed cases.
// Randomized traffic with mid-frame input changes and an asynchronous reset.
module tb_uart_tx_ctrl;
  localparam int CPB = 4;
`ifdef UART_TX_STOP2_EN
  localparam int NSTOP = 2;
`else
  localparam int NSTOP = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_tx_ctrl_if bus();

  uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Model: the remaining line samples of the current frame, one entry per clock.
  bit         m_q[$];
  bit         m_done = 1'b0;
  bit         m_par  = 1'b0;
  logic [7:0] m_dat  = '0;
  logic [1:0] m_typ  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit ref_parity(input logic [7:0] d, input logic [1:0] t);
    int ones;
    ones = $countones(d);
    case (t)
      2'b01, 2'b11: return (ones % 2) == 0;
      2'b10:        return (ones % 2) == 1;
      default:      return 1'b0;
    endcase
  endfunction

  task automatic model_push(input logic [7:0] d, input logic [1:0] t);
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (t == 2'b01 || t == 2'b10) bits.push_back(ref_parity(d, t));
    for (int i = 0; i < NSTOP; i++) bits.push_back(1'b1);
    foreach (bits[b]) for (int c = 0; c < CPB; c++) m_q.push_back(bits[b]);
  endtask

  // Model advance: one line sample consumed per clock; idle clocks may accept a request.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q.delete();
      m_done = 1'b0;
      m_par  = 1'b0;
      m_dat  = '0;
      m_typ  = '0;
    end else begin
      m_par  = ref_parity(m_dat, m_typ);
      m_done = 1'b0;
      if (m_q.size() != 0) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_done = 1'b1;
      end else if (bus.data_valid) begin
        m_dat = bus.data_in;
        m_typ = bus.parity_type;
        model_push(m_dat, m_typ);
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    check("tx_out",  bus.tx_out,  (m_q.size() != 0) ? m_q[0] : 1'b1);
    check("busy",    bus.busy,    m_q.size() != 0);
    check("done",    bus.done,    m_done);
    check("par_bit", bus.par_bit, m_par);
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bus.busy || bus.done) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", bus.busy, 0);
  endtask

  // Sends one frame, scrambles inputs mid-frame, records busy length, done clock and bit image.
  task automatic send_capture(input logic [7:0] d, input logic [1:0] t,
                              output int busy_n, output int done_at, output logic [15:0] bitv);
    int idx;
    busy_n  = 0;
    done_at = 0;
    bitv    = '0;
    @(negedge clk);
    #1;
    bus.data_valid  = 1'b1;
    bus.data_in     = d;
    bus.parity_type = t;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (bus.busy) begin
        busy_n++;
        idx = (busy_n - 1) / CPB;
        if (((busy_n - 1) % CPB) == 0 && idx < 16) bitv[idx] = bus.tx_out;
      end
      if (bus.done) begin
        done_at = k;
        break;
      end
      if (k == 1) begin
        #1;
        bus.data_valid  = 1'b0;
        bus.data_in     = ~d;
        bus.parity_type = ~t;
      end
    end
    check("frame_done_seen", done_at > 0, 1);
  endtask

  initial begin
    logic [15:0] bv;
    int bn;
    int da;
    int n;

    // Reset held with a request pending: nothing may start.
    bus.data_valid  = 1'b1;
    bus.data_in     = 8'h5A;
    bus.parity_type = 2'b01;
    repeat (3) @(negedge clk);
    check("rst_tx",   bus.tx_out,  1);
    check("rst_busy", bus.busy,    0);
    check("rst_done", bus.done,    0);
    check("rst_par",  bus.par_bit, 0);
    #2 rst = 1'b1;
    @(negedge clk);
    check("first_start_tx",   bus.tx_out, 0);
    check("first_start_busy", bus.busy,   1);
    #1 bus.data_valid = 1'b0;
    wait_idle();

    // 0x55 odd parity.
    send_capture(8'h55, 2'b01, bn, da, bv);
    check("f55_busy_len", bn, CPB * (10 + NSTOP));
    check("f55_done_clk", da, CPB * (10 + NSTOP) + 1);
    check("f55_bits",     bv[10:0], 11'h6AA);
    check("f55_par",      bus.par_bit, 1);
    wait_idle();

    // 0xA7 even parity, data_in changed mid-frame.
    send_capture(8'hA7, 2'b10, bn, da, bv);
    check("fa7_busy_len", bn, CPB * (10 + NSTOP));
    check("fa7_bits",     bv[10:0], 11'h74E);
    check("fa7_par",      bus.par_bit, 1);
    wait_idle();

    // 0x00 with reported-only odd parity, then no parity.
    send_capture(8'h00, 2'b11, bn, da, bv);
    check("f00t3_busy_len", bn, CPB * (9 + NSTOP));
    check("f00t3_bits",     bv[9:0], 10'h200);
    check("f00t3_par",      bus.par_bit, 1);
    wait_idle();
    send_capture(8'h00, 2'b00, bn, da, bv);
    check("f00t0_busy_len", bn, CPB * (9 + NSTOP));
    check("f00t0_par",      bus.par_bit, 0);
    wait_idle();

    // Back-to-back with data_valid held high; second byte taken on the done cycle.
    @(negedge clk);
    #1;
    bus.data_valid  = 1'b1;
    bus.data_in     = 8'h3C;
    bus.parity_type = 2'b01;
    @(negedge clk);
    #1;
    bus.data_in     = 8'hC3;
    bus.parity_type = 2'b10;
    n = 0;
    while (!bus.done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("b2b_done1", bus.done,    1);
    check("b2b_par1",  bus.par_bit, 1);
    @(negedge clk);
    check("b2b_restart_busy", bus.busy,   1);
    check("b2b_restart_tx",   bus.tx_out, 0);
    #1 bus.data_valid = 1'b0;
    repeat (CPB * 5) @(negedge clk);
    #1 bus.data_valid = 1'b1;
    @(negedge clk);
    #1 bus.data_valid = 1'b0;
    wait_idle();
    check("b2b_par2", bus.par_bit, 0);
    repeat (2 * CPB) @(negedge clk);
    check("b2b_no_extra", bus.busy, 0);

    // Asynchronous reset during data bit 3, then a clean frame.
    @(negedge clk);
    #1;
    bus.data_valid  = 1'b1;
    bus.data_in     = 8'h96;
    bus.parity_type = 2'b01;
    @(negedge clk);
    #1 bus.data_valid = 1'b0;
    repeat (4 * CPB + 1) @(negedge clk);
    check("mid_busy", bus.busy,    1);
    check("mid_par",  bus.par_bit, 1);
    #2 rst = 1'b0;
    #1;
    check("arst_tx",   bus.tx_out,  1);
    check("arst_busy", bus.busy,    0);
    check("arst_par",  bus.par_bit, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    send_capture(8'h96, 2'b01, bn, da, bv);
    check("f96_busy_len", bn, CPB * (10 + NSTOP));
    check("f96_bits",     bv[10:0], 11'h72C);
    wait_idle();

    // Random traffic with an asynchronous reset in the middle.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      #1;
      bus.data_valid  = ($urandom_range(0, 9) == 0);
      bus.data_in     = 8'($urandom);
      bus.parity_type = 2'($urandom);
      if (c == 1500) begin
        rst = 1'b0;
        #3 rst = 1'b1;
      end
    end
    bus.data_valid = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
